inst_fetch_unit: RTL
====================

# inst_fetch_unit

Instruction-side sram-like master for the blocking MIPS core. It issues one word fetch per PC over the sram-like instruction port and holds the returned word in a buffer until the pipeline advances. It then presents that word as `instr_o` to the F/D register that feeds the decode controller. It raises `i_stall_o` while a fetch is in flight, and it discards responses belonging to a flushed PC.

## Interface
Parameters:
- `RESET_PC`, 32'hBFC0_0000: value of `instr_pc_o` after reset.

Ports:
- `clk` in 1: core clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `pc_i` in 32: current fetch PC from the PC register; held stable by the hazard unit while `i_stall_o`=1, except on flush.
- `stall_i` in 1: downstream stall (F/D not accepting), excluding this block's own stall.
- `flush_i` in 1: exception/eret flush; the PC register loads its new value at this edge regardless of stall.
- `inst_req` out 1: sram-like request.
- `inst_wr` out 1: constant 0.
- `inst_size` out 2: constant 2'b10.
- `inst_addr` out 32: request address, equal to `pc_i`.
- `inst_wdata` out 32: constant 0.
- `inst_addr_ok` in 1: address handshake.
- `inst_data_ok` in 1: data return.
- `inst_rdata` in 32: returned word.
- `instr_o` out 32: buffered instruction, delivered to decode.
- `instr_pc_o` out 32: PC of `instr_o`.
- `instr_valid_o` out 1: `instr_o` is valid for the current PC.
- `adel_o` out 1: fetch address error for `instr_pc_o`.
- `i_stall_o` out 1: fetch not complete; stalls F and above.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- `cancel` register: marks an outstanding response as belonging to a flushed PC.
- IDLE: `inst_req`=0. Transitions to REQ on the next cycle unconditionally.
- REQ: `inst_req`=1 and `inst_addr`=`pc_i`.
  - On `inst_addr_ok`: latch `pc_i` into the PC buffer, then go to WAIT. Set `cancel`=`flush_i`.
  - Without `inst_addr_ok`: hold `inst_req`. Never withdraw a request before `addr_ok`, even on flush.
  - `flush_i` without `addr_ok`: stay in REQ. The address follows the new `pc_i`. This is legal because no handshake has occurred.
- WAIT: `inst_req`=0.
  - `inst_data_ok` is only sampled in WAIT.
  - `flush_i` sets `cancel`.
  - On `inst_data_ok` with `cancel`=0 and no flush this cycle: capture `inst_rdata` into `instr_o`, then go to DONE.
  - On `inst_data_ok` with `cancel`=1, or with `flush_i` this cycle: drop the data, clear `cancel`, go to REQ.
- DONE: the buffer is held.
  - `stall_i`=0: the pipeline consumes the word this edge; go to REQ.
  - `stall_i`=1: stay in DONE.
  - `flush_i`: go to REQ and invalidate the buffer.
- `i_stall_o` = (state != DONE). It is high in IDLE, REQ and WAIT.
- `instr_valid_o` = (state == DONE). When it is 0, `instr_o` is forced to 0 (nop toward decode).
- At most one outstanding request exists at any time.

## Timing
- Reset values:
  - `inst_req`=0
  - `instr_o`=0
  - `instr_pc_o`=`RESET_PC`
  - `instr_valid_o`=0
  - `adel_o`=0
  - `i_stall_o`=1
  - `cancel`=0
  - state=IDLE
- Best case: REQ with `addr_ok` at cycle n, `data_ok` at cycle n+1, `instr_valid_o`=1 at cycle n+2.
- Throughput: one instruction per 3 cycles minimum.
- Each extra cycle of `addr_ok` or `data_ok` latency adds one cycle of stall.
- `rst` asserted in any state returns the block to IDLE at the next edge. Any in-flight response after reset is the interconnect's responsibility; it is also reset by `rst`.
- `flush_i` together with `data_ok` in WAIT: the data is discarded; no valid word is produced.

## Configuration
- `FETCH_ADEL_CHECK_EN` defined:
  - In REQ with `pc_i[1:0]`!=0: no request is issued (`inst_req`=0).
  - The block latches the PC, sets `instr_o`=0 and `adel_o`=1, and goes straight to DONE.
  - `adel_o` clears on leaving DONE.
- `FETCH_ADEL_CHECK_EN` undefined:
  - No alignment check; a request is issued for every PC.
  - `adel_o` is tied to 0.

## Test plan
- Reset then zero-latency memory (`addr_ok` same cycle, `data_ok` next), `pc_i`=32'hBFC0_0000, `rdata`=32'h2408_0001 -> `instr_valid_o`=1 at cycle 3 after reset release, with `instr_o`=32'h2408_0001 and `instr_pc_o`=32'hBFC0_0000.
- `addr_ok` delayed 3 cycles and `data_ok` delayed 2 -> `inst_req` stays high for 4 cycles with constant `inst_addr`; `i_stall_o`=1 throughout; the word is valid 1 cycle after `data_ok`.
- `stall_i`=1 for 5 cycles while in DONE -> `instr_o` held, no new `inst_req`; on `stall_i`=0, REQ follows on the next cycle with the new `pc_i`.
- `flush_i` in WAIT, `data_ok` 2 cycles later with 32'hDEAD_BEEF, new `pc_i`=32'hBFC0_0380 -> DEAD_BEEF is never valid; the next request is to 32'hBFC0_0380.
- `flush_i` and `data_ok` in the same cycle -> data dropped; the next state is REQ.
- With `FETCH_ADEL_CHECK_EN` defined, `pc_i`=32'hBFC0_0002 -> `inst_req` never asserted; `adel_o`=1, `instr_o`=0 and `instr_valid_o`=1 one cycle after REQ.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction-side sram-like fetch master: one word per PC, buffered until F/D accepts it.
// Optional alignment check (address error, no bus request) under `FETCH_ADEL_CHECK_EN.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    output logic        adel_o,
    output logic        i_stall_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        cancel;
    logic [31:0] pc_buf;
    logic [31:0] instr_buf;
    logic        misalign;
    logic        adel_q;
    logic        accept;
    logic        capture;

`ifdef FETCH_ADEL_CHECK_EN
    assign misalign = (pc_i[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // A misaligned PC seen during a flush is stale; wait for the new one.
    assign accept  = (state == REQ) && !misalign && inst_addr_ok;
    assign capture = (state == WAIT) && inst_data_ok && !cancel && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: next_state = REQ;
            REQ: begin
                if (misalign) begin
                    next_state = flush_i ? REQ : DONE;
                end else if (inst_addr_ok) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (inst_data_ok) begin
                    next_state = (cancel || flush_i) ? REQ : DONE;
                end
            end
            DONE: begin
                if (flush_i || !stall_i) begin
                    next_state = REQ;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cancel    <= 1'b0;
            pc_buf    <= RESET_PC;
            instr_buf <= 32'h0;
        end else begin
            if (accept) begin
                cancel <= flush_i;
                pc_buf <= pc_i;
            end else if (state == WAIT) begin
                if (inst_data_ok) begin
                    cancel <= 1'b0;
                end else if (flush_i) begin
                    cancel <= 1'b1;
                end
            end
            if (capture) begin
                instr_buf <= inst_rdata;
            end
            if ((state == REQ) && misalign && !flush_i) begin
                pc_buf    <= pc_i;
                instr_buf <= 32'h0;
            end
        end
    end

`ifdef FETCH_ADEL_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            adel_q <= 1'b0;
        end else if ((state == REQ) && misalign && !flush_i) begin
            adel_q <= 1'b1;
        end else if ((state == DONE) && (next_state != DONE)) begin
            adel_q <= 1'b0;
        end
    end
`else
    assign adel_q = 1'b0;
`endif

    always_comb begin
        inst_req      = (state == REQ) && !misalign;
        inst_wr       = 1'b0;
        inst_size     = 2'b10;
        inst_addr     = pc_i;
        inst_wdata    = 32'h0;
        instr_valid_o = (state == DONE);
        i_stall_o     = (state != DONE);
        instr_o       = instr_valid_o ? instr_buf : 32'h0;
        instr_pc_o    = pc_buf;
        adel_o        = adel_q;
    end

endmodule
